sw_stimulus_player: RTL and testbench

//  Synthesisable stimulus sequencer: replays a programmable table of (value, hold-time) steps onto
//  a WIDTH-bit switch bus and emits an active-low reset pulse before the first step. It drives

---
 rtl/sw_stimulus_player_if.sv | 46 ++++
 rtl/sw_stimulus_player.sv | 155 +++++++++++++++
 tb/tb_sw_stimulus_player.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_stimulus_player_if.sv
// Control and observation bundle for sw_stimulus_player.
// The loop input exists only when STIM_LOOP_EN is defined.
interface sw_stimulus_player_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int CNT_W = 24
) ();
  localparam int AW = $clog2(DEPTH);

  // wr_en, start and stop are plain strobes/levels with no ready back-pressure:
  // a write is accepted only in IDLE (otherwise dropped and flagged by wr_err),
  // start is a level sampled only in IDLE, and stop is honoured in any busy state.
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_value;
  logic [CNT_W-1:0] wr_hold;
  logic [AW:0]      num_steps;
  logic             start;
  logic             stop;
`ifdef STIM_LOOP_EN
  logic             loop;
`endif
  logic [WIDTH-1:0] sw_out;
  logic             rst_pulse_n;
  logic             busy;
  logic [AW-1:0]    step_idx;
  logic             done;
  logic             wr_err;
  logic [1:0]       state;

  modport master (
    output wr_en, wr_addr, wr_value, wr_hold, num_steps, start, stop,
`ifdef STIM_LOOP_EN
    output loop,
`endif
    input  sw_out, rst_pulse_n, busy, step_idx, done, wr_err, state
  );

  modport slave (
    input  wr_en, wr_addr, wr_value, wr_hold, num_steps, start, stop,
`ifdef STIM_LOOP_EN
    input  loop,
`endif
    output sw_out, rst_pulse_n, busy, step_idx, done, wr_err, state
  );
endinterface

// File: rtl/sw_stimulus_player.sv
// Replays a table of (value, hold) steps onto a switch bus after an active-low reset pulse.
// Optional macro STIM_LOOP_EN: restart at step 0 (no new reset pulse) while loop is high.
module sw_stimulus_player #(
  parameter int WIDTH      = 10,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 24,
  parameter int RST_CYCLES = 2
) (
  input logic               CLOCK_50,
  input logic               resetn,
  sw_stimulus_player_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RST = 2'd1, HOLD = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] val_mem  [DEPTH];
  logic [CNT_W-1:0] hold_mem [DEPTH];

  logic [WIDTH-1:0] sw_q, sw_nxt;
  logic             rstp_q, rstp_nxt;
  logic             busy_q, busy_nxt;
  logic [AW-1:0]    idx_q, idx_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [RW-1:0]    rcnt_q, rcnt_nxt;
  logic [NW-1:0]    n_q, n_nxt;

  logic [AW-1:0]    idx_inc;
  logic             last_step;
  logic [NW-1:0]    n_clamp;
  logic [WIDTH-1:0] start_val;

  function automatic logic [CNT_W-1:0] eff_hold(input logic [CNT_W-1:0] h);
    return (h == '0) ? CNT_W'(1) : h;
  endfunction

  // Table is deliberately not reset; writes only land while idle.
  always_ff @(posedge CLOCK_50) begin
    if (bus.wr_en && state == IDLE) begin
      val_mem[bus.wr_addr]  <= bus.wr_value;
      hold_mem[bus.wr_addr] <= bus.wr_hold;
    end
  end

  assign idx_inc   = idx_q + AW'(1);
  assign last_step = ({1'b0, idx_q} == n_q - NW'(1));
  assign n_clamp   = (bus.num_steps > NW'(DEPTH)) ? NW'(DEPTH) : bus.num_steps;
  // A write to entry 0 in the start cycle must be visible as the first value.
  assign start_val = (bus.wr_en && bus.wr_addr == '0) ? bus.wr_value : val_mem[0];

  always_comb begin
    state_nxt = state;
    sw_nxt    = sw_q;
    rstp_nxt  = rstp_q;
    busy_nxt  = busy_q;
    idx_nxt   = idx_q;
    done_nxt  = 1'b0;
    err_nxt   = bus.wr_en && (state != IDLE);
    cnt_nxt   = cnt_q;
    rcnt_nxt  = rcnt_q;
    n_nxt     = n_q;
    if (state != IDLE && bus.stop) begin
      state_nxt = IDLE;
      rstp_nxt  = 1'b1;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && bus.num_steps != '0) begin
            state_nxt = RST;
            n_nxt     = n_clamp;
            sw_nxt    = start_val;
            idx_nxt   = '0;
            rstp_nxt  = 1'b0;
            busy_nxt  = 1'b1;
            rcnt_nxt  = RW'(RST_CYCLES - 1);
          end
        end
        RST: begin
          if (rcnt_q == '0) begin
            rstp_nxt  = 1'b1;
            cnt_nxt   = eff_hold(hold_mem[0]);
            state_nxt = HOLD;
          end else begin
            rcnt_nxt = rcnt_q - RW'(1);
          end
        end
        HOLD: begin
          // Counter holds the remaining cycles of the current step, so it never wraps.
          if (cnt_q <= CNT_W'(1)) begin
            if (!last_step) begin
              sw_nxt  = val_mem[idx_inc];
              idx_nxt = idx_inc;
              cnt_nxt = eff_hold(hold_mem[idx_inc]);
            end
`ifdef STIM_LOOP_EN
            else if (bus.loop) begin
              sw_nxt  = val_mem[0];
              idx_nxt = '0;
              cnt_nxt = eff_hold(hold_mem[0]);
            end
`endif
            else begin
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      sw_q   <= '0;
      rstp_q <= 1'b1;
      busy_q <= 1'b0;
      idx_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      rcnt_q <= '0;
      n_q    <= '0;
    end else begin
      state  <= state_nxt;
      sw_q   <= sw_nxt;
      rstp_q <= rstp_nxt;
      busy_q <= busy_nxt;
      idx_q  <= idx_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      cnt_q  <= cnt_nxt;
      rcnt_q <= rcnt_nxt;
      n_q    <= n_nxt;
    end
  end

  assign bus.sw_out      = sw_q;
  assign bus.rst_pulse_n = rstp_q;
  assign bus.busy        = busy_q;
  assign bus.step_idx    = idx_q;
  assign bus.done        = done_q;
  assign bus.wr_err      = err_q;
  assign bus.state       = state;
endmodule

// File: tb/tb_sw_stimulus_player.sv
// Bench for sw_stimulus_player: per-cycle expected trace built from a shadow table,
// pushed to exp_q when a sequence is started and popped one entry per clock.
module tb_sw_stimulus_player;
  localparam int WIDTH = 10, DEPTH = 8, CNT_W = 24, RST_CYCLES = 2;
  localparam int W = 16;  // {busy, rst_pulse_n, done, step_idx[2:0], sw_out[9:0]}

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sw_stimulus_player_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  sw_stimulus_player #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  logic [WIDTH-1:0] sh_val  [DEPTH];
  logic [CNT_W-1:0] sh_hold [DEPTH];
  logic [W-1:0]     exp_q[$];
  logic [WIDTH-1:0] last_sw;
  logic [2:0]       last_idx;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int               n_req;
    logic [WIDTH-1:0] base;
    int               hmax;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [W-1:0] mk(bit b, bit r, bit d, logic [2:0] i, logic [WIDTH-1:0] s);
    return {b, r, d, i, s};
  endfunction

  function automatic logic [W-1:0] obs();
    return {bus.busy, bus.rst_pulse_n, bus.done, bus.step_idx, bus.sw_out};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected samples taken #1 after each edge, starting with the edge that sees start.
  task automatic push_trace(int n_req, int passes, bit tail);
    int n;
    int h;
    n = (n_req > DEPTH) ? DEPTH : n_req;
    if (n == 0) begin
      repeat (3) exp_q.push_back(mk(0, 1, 0, last_idx, last_sw));
      return;
    end
    for (int c = 0; c < RST_CYCLES; c++) exp_q.push_back(mk(1, 0, 0, 3'd0, sh_val[0]));
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < n; k++) begin
        h = (sh_hold[k] == '0) ? 1 : int'(sh_hold[k]);
        for (int c = 0; c < h; c++) exp_q.push_back(mk(1, 1, 0, 3'(k), sh_val[k]));
      end
    end
    last_sw  = sh_val[n-1];
    last_idx = 3'(n - 1);
    exp_q.push_back(mk(0, 1, 1, last_idx, last_sw));
    if (tail) exp_q.push_back(mk(0, 1, 0, last_idx, last_sw));
  endtask

  task automatic wr(int a, logic [WIDTH-1:0] v, logic [CNT_W-1:0] h);
    @(negedge clk);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 3'(a);
    bus.wr_value = v;
    bus.wr_hold  = h;
    @(posedge clk);
    #1;
    check("wr_err_idle", {31'd0, bus.wr_err}, 32'd0);
    bus.wr_en = 1'b0;
    sh_val[a]  = v;
    sh_hold[a] = h;
  endtask

  task automatic run_seq(string name, int n_req, int drop_start, int drop_loop);
    int idx;
    @(negedge clk);
    bus.num_steps = 4'(n_req);
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    idx = 0;
    while (exp_q.size() > 0) begin
      check(name, {16'd0, obs()}, {16'd0, exp_q.pop_front()});
      if (idx == drop_start) bus.start = 1'b0;
`ifdef STIM_LOOP_EN
      if (idx == drop_loop) bus.loop = 1'b0;
`endif
      idx++;
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic play(string name, int n_req);
    push_trace(n_req, 1, 1'b1);
    run_seq(name, n_req, 0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1,  10'h3F0, 4};
    vecs[1] = '{4,  10'h100, 3};
    vecs[2] = '{8,  10'h2A0, 2};
    vecs[3] = '{15, 10'h055, 1};
    vecs[4] = '{6,  10'h011, 0};

    resetn = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_value = '0; bus.wr_hold = '0;
    bus.num_steps = '0; bus.start = 1'b0; bus.stop = 1'b0;
`ifdef STIM_LOOP_EN
    bus.loop = 1'b0;
`endif
    last_sw = '0;
    last_idx = '0;

    // Reset values
    #12;
    check("rst_sw_out", {22'd0, bus.sw_out}, 32'd0);
    check("rst_pulse_n", {31'd0, bus.rst_pulse_n}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_wr_err", {31'd0, bus.wr_err}, 32'd0);
    check("rst_step_idx", {29'd0, bus.step_idx}, 32'd0);
    check("rst_state", {30'd0, bus.state}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Basic two-step sequence
    wr(0, 10'h04C, 5);
    wr(1, 10'h041, 3);
    play("basic", 2);

    // Zero hold means one cycle
    wr(0, 10'h155, 0);
    wr(1, 10'h0AA, 0);
    wr(2, 10'h3C3, 1);
    play("hold0", 3);

    // num_steps == 0 is ignored
    play("nsteps0", 0);

    // Table-driven vectors, including clamp of 15 to DEPTH
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < DEPTH; i++)
        wr(i, vecs[v].base + WIDTH'(i * 'h23), CNT_W'($urandom_range(0, vecs[v].hmax)));
      play($sformatf("vec%0d", v), vecs[v].n_req);
    end

    // Write while busy is dropped; stop during step 1
    wr(0, 10'h111, 4);
    wr(1, 10'h222, 4);
    wr(2, 10'h333, 4);
    @(negedge clk);
    bus.num_steps = 4'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_value = 10'h3FF; bus.wr_hold = 24'd1;
    @(posedge clk);
    #1;
    check("wr_err_busy", {31'd0, bus.wr_err}, 32'd1);
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;
    check("wr_err_clear", {31'd0, bus.wr_err}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("stop_pre_idx", {29'd0, bus.step_idx}, 32'd1);
    check("stop_pre_sw", {22'd0, bus.sw_out}, 32'h222);
    @(negedge clk);
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    check("stop_obs", {16'd0, obs()}, {16'd0, mk(0, 1, 0, 3'd1, 10'h222)});
    check("stop_state", {30'd0, bus.state}, 32'd0);
    @(posedge clk);
    #1;
    check("stop_nodone", {16'd0, obs()}, {16'd0, mk(0, 1, 0, 3'd1, 10'h222)});
    last_sw = 10'h222;
    last_idx = 3'd1;
    play("replay", 3);

    // Held-high start re-triggers right after done
    wr(0, 10'h0F0, 2);
    push_trace(1, 1, 1'b0);
    push_trace(1, 1, 1'b1);
    run_seq("retrig", 1, RST_CYCLES + 2 + 1, -1);

`ifdef STIM_LOOP_EN
    // Loop: three full periods, one reset pulse, loop dropped during the third pass
    wr(0, 10'h0C3, 2);
    wr(1, 10'h13C, 3);
    bus.loop = 1'b1;
    push_trace(2, 3, 1'b1);
    run_seq("loop", 2, 0, RST_CYCLES + 2 * 5);
`endif

    // Asynchronous reset mid-HOLD
    wr(0, 10'h2AA, 10);
    @(negedge clk);
    bus.num_steps = 4'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_areset_busy", {31'd0, bus.busy}, 32'd1);
    resetn = 1'b0;
    #1;
    check("areset_obs", {16'd0, obs()}, {16'd0, mk(0, 1, 0, 3'd0, 10'h000)});
    check("areset_state", {30'd0, bus.state}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    last_sw = '0;
    last_idx = '0;
    wr(0, 10'h1E1, 3);
    play("post_reset", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
